// File: rtl/alu_sequencer_if.sv
// Command and result handshakes of the ALU sequencer.
// The master side issues commands and consumes results.
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;
  logic             res_zero;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_cout, res_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Drives a combinational ALU: holds operands for a settle time,
// captures the result into an accumulator and returns it.
module alu_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       ALU_option,
  output logic [WIDTH-1:0] ALU_in1,
  output logic [WIDTH-1:0] ALU_in2,
  input  logic [WIDTH-1:0] ALU_out,
  input  logic             ALU_Cout
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_chk
    $error("SETTLE_CYCLES out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic             cout_q;
  logic             cmd_ready;
  logic             res_valid;
  logic             arith;

  // Carry is only meaningful for add (000) and sub (001).
  assign arith = (ALU_option == 3'b000)
              || (ALU_option == 3'b001);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      cout_q     <= 1'b0;
      ALU_option <= '0;
      ALU_in2    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            ALU_option <= bus.cmd_op;
            ALU_in2    <= bus.cmd_data;
            cnt_q      <= CNT_INIT;
            if (bus.cmd_load) begin
              acc_q  <= bus.cmd_data;
              cout_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
        end
        CAPTURE: begin
          acc_q  <= ALU_out;
          cout_q <= arith & ALU_Cout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid)
          state_d = bus.cmd_load ? RESP : ISSUE;
      end
      ISSUE: begin
        if (cnt_q == 4'd0)
          state_d = CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (bus.res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ALU_in1       = acc_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = acc_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_zero  = (acc_q == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with SETTLE_CYCLES of 1 and 4,
// each DUT driving a small behavioural ALU.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst4, sel, cv, cl, rr;
  logic [2:0] op;
  logic [3:0] cd;
  int total = 0;
  int passed = 0;
  int n;

  alu_sequencer_if #(.WIDTH(4)) c1 ();
  alu_sequencer_if #(.WIDTH(4)) c4 ();

  assign c1.cmd_valid = cv & ~sel;
  assign c4.cmd_valid = cv & sel;
  assign c1.res_ready = rr & ~sel;
  assign c4.res_ready = rr & sel;
  assign c1.cmd_load  = cl;
  assign c4.cmd_load  = cl;
  assign c1.cmd_op    = op;
  assign c4.cmd_op    = op;
  assign c1.cmd_data  = cd;
  assign c4.cmd_data  = cd;

  // Behavioural ALU; non-arith ops report carry 1 to expose masking.
  function automatic logic [4:0] alu(
    input logic [2:0] o,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] r;
    case (o)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {(a < b), 4'(a - b)};
      3'b010:  r = {1'b1, a & b};
      3'b011:  r = {1'b1, a | b};
      3'b100:  r = {1'b1, a ^ b};
      default: r = {1'b1, a};
    endcase
    return r;
  endfunction

  logic [2:0] opt1, opt4;
  logic [3:0] in1_1, in2_1, out1, in1_4, in2_4, out4;
  logic co1, co4;

  assign {co1, out1} = alu(opt1, in1_1, in2_1);
  assign {co4, out4} = alu(opt4, in1_4, in2_4);

  alu_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(c1.slave),
    .ALU_option(opt1), .ALU_in1(in1_1), .ALU_in2(in2_1),
    .ALU_out(out1), .ALU_Cout(co1)
  );

  alu_sequencer #(.WIDTH(4), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(rst4), .bus(c4.slave),
    .ALU_option(opt4), .ALU_in1(in1_4), .ALU_in2(in2_4),
    .ALU_out(out4), .ALU_Cout(co4)
  );

  wire       m_ready = sel ? c4.cmd_ready : c1.cmd_ready;
  wire       m_valid = sel ? c4.res_valid : c1.res_valid;
  wire [3:0] m_data  = sel ? c4.res_data  : c1.res_data;
  wire       m_cout  = sel ? c4.res_cout  : c1.res_cout;
  wire       m_zero  = sel ? c4.res_zero  : c1.res_zero;
  wire [3:0] m_in1   = sel ? in1_4 : in1_1;
  wire [3:0] m_in2   = sel ? in2_4 : in2_1;
  wire [2:0] m_opt   = sel ? opt4  : opt1;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic s, input logic l,
                      input logic [2:0] o, input logic [3:0] d);
    @(negedge clk);
    sel = s; cv = 1'b1; cl = l; op = o; cd = d;
    #1 check("cmd_ready_pre", 8'(m_ready), 8'h1);
    @(posedge clk);
    #1 cv = 1'b0;
  endtask

  task automatic wait_res(input int start, output int cnt);
    cnt = start;
    do begin
      @(negedge clk);
      cnt++;
    end while (!m_valid && cnt < 20);
  endtask

  task automatic take();
    @(negedge clk);
    rr = 1'b1;
    @(posedge clk);
    #1 rr = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; sel = 1'b0;
    cv = 1'b0; cl = 1'b0; rr = 1'b0; op = '0; cd = '0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 8'(m_ready), 8'h1);
    check("rst_res_valid", 8'(m_valid), 8'h0);
    check("rst_res_data",  8'(m_data),  8'h0);
    check("rst_res_zero",  8'(m_zero),  8'h1);
    check("rst_res_cout",  8'(m_cout),  8'h0);
    check("rst_alu_opt",   8'(m_opt),   8'h0);
    check("rst_alu_in2",   8'(m_in2),   8'h0);

    // Load 0101
    send(1'b0, 1'b1, 3'b000, 4'b0101);
    wait_res(0, n);
    check("load_latency", 8'(n), 8'd1);
    check("load_data", 8'(m_data), 8'h5);
    check("load_cout", 8'(m_cout), 8'h0);
    check("load_zero", 8'(m_zero), 8'h0);
    take();

    // 1111 + 0001 wraps to 0000 with carry
    send(1'b0, 1'b1, 3'b000, 4'b1111);
    wait_res(0, n);
    take();
    send(1'b0, 1'b0, 3'b000, 4'b0001);
    @(negedge clk);
    check("add_in1", 8'(m_in1), 8'hf);
    check("add_in2", 8'(m_in2), 8'h1);
    check("add_opt", 8'(m_opt), 8'h0);
    check("add_busy", 8'(m_ready), 8'h0);
    wait_res(1, n);
    check("add_latency", 8'(n), 8'd3);
    check("add_data", 8'(m_data), 8'h0);
    check("add_cout", 8'(m_cout), 8'h1);
    check("add_zero", 8'(m_zero), 8'h1);
    take();

    // 1100 AND 1010 with back-pressure
    send(1'b0, 1'b1, 3'b000, 4'b1100);
    wait_res(0, n);
    take();
    send(1'b0, 1'b0, 3'b010, 4'b1010);
    wait_res(0, n);
    check("and_latency", 8'(n), 8'd3);
    check("and_cout", 8'(m_cout), 8'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 8'(m_valid), 8'h1);
      check("bp_data", 8'(m_data), 8'h8);
      check("bp_ready", 8'(m_ready), 8'h0);
      if (i == 2) begin
        cv = 1'b1; cl = 1'b1; cd = 4'b0000;
      end else begin
        cv = 1'b0;
      end
    end
    cv = 1'b0;
    take();
    @(negedge clk);
    check("post_ready", 8'(m_ready), 8'h1);
    check("post_valid", 8'(m_valid), 8'h0);
    check("post_data", 8'(m_data), 8'h8);

    // 1000 XOR 0110: carry masked
    send(1'b0, 1'b0, 3'b100, 4'b0110);
    wait_res(0, n);
    check("xor_latency", 8'(n), 8'd3);
    check("xor_data", 8'(m_data), 8'he);
    check("xor_cout", 8'(m_cout), 8'h0);
    take();

    // SETTLE_CYCLES=4: 0011 - 0101
    send(1'b1, 1'b1, 3'b000, 4'b0011);
    wait_res(0, n);
    check("load4_latency", 8'(n), 8'd1);
    take();
    send(1'b1, 1'b0, 3'b001, 4'b0101);
    wait_res(0, n);
    check("sub4_latency", 8'(n), 8'd6);
    check("sub4_data", 8'(m_data), 8'he);
    check("sub4_cout", 8'(m_cout), 8'h1);
    check("sub4_zero", 8'(m_zero), 8'h0);
    take();

    // Reset while in ISSUE
    send(1'b1, 1'b0, 3'b000, 4'b0001);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 8'(m_ready), 8'h0);
    rst4 = 1'b1;
    @(posedge clk);
    #1 rst4 = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 8'(m_ready), 8'h1);
    check("mid_rst_valid", 8'(m_valid), 8'h0);
    check("mid_rst_data", 8'(m_data), 8'h0);
    check("mid_rst_opt", 8'(m_opt), 8'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale", 8'(m_valid), 8'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
